// File: rtl/param_data_memory.sv
// param_data_memory: parametrised word-addressed data memory.
// The memory is preloaded by a sequential init sweep after reset, so the array
// itself has no reset and can map onto block RAM. It has a registered read port
// with a valid strobe and checks the address range on every request.
module param_data_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 32
) (
    input  logic                  Oscillator,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  ReadValid,
    output logic                  AddrError,
    output logic                  Busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // The range limit is one bit wider than Address so DEPTH == 2^ADDR_WIDTH still fits.
    localparam logic [ADDR_WIDTH:0]   DEPTH_A  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]        HALF_I   = (IDX_W+1)'(DEPTH / 2);
    localparam logic [DATA_WIDTH-1:0] HALF_D   = DATA_WIDTH'(DEPTH / 2);

    localparam logic [0:0] S_INIT  = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [0:0]            r_state;
    logic [IDX_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_aerr;

    logic                  w_ready;
    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_wr_ok;
    logic                  w_rd;
    logic [DATA_WIDTH-1:0] w_init_val;
    logic [DATA_WIDTH-1:0] w_rd_val;

    assign w_ready    = (r_state == S_READY);
    // Full-width compare: addresses at or above DEPTH are never folded back into range.
    assign w_in_range = ({1'b0, Address} < DEPTH_A);
    assign w_idx      = Address[IDX_W-1:0];
    assign w_wr_ok    = w_ready & MemWrite & w_in_range;
    assign w_rd       = w_ready & MemRead;

    // Lower half preloads with its index, upper half with -(i - DEPTH/2).
    // Done modulo 2^DATA_WIDTH, so truncation falls out naturally.
    assign w_init_val = ({1'b0, r_cnt} < HALF_I) ? DATA_WIDTH'(r_cnt)
                                                 : (HALF_D - DATA_WIDTH'(r_cnt));

    // Write-first: a same-cycle write to the read address forwards WriteData.
    // Out-of-range reads return zero.
    assign w_rd_val = !w_in_range ? '0 :
                      (MemWrite ? WriteData : r_mem[w_idx]);

    // Init sweep counter and state: one word per cycle, then READY.
    always_ff @(posedge Oscillator or posedge Reset) begin
        if (Reset) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else if (r_state == S_INIT) begin
            if (r_cnt == LAST_IDX) begin
                r_state <= S_READY;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Memory array write port: preload during the sweep, user writes once ready.
    always_ff @(posedge Oscillator) begin
        if (!w_ready) begin
            r_mem[r_cnt] <= w_init_val;
        end else if (w_wr_ok) begin
            r_mem[w_idx] <= WriteData;
        end
    end

    // Registered read port and the request status strobes.
    always_ff @(posedge Oscillator or posedge Reset) begin
        if (Reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_aerr   <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            r_aerr   <= w_ready & (MemRead | MemWrite) & ~w_in_range;
            if (w_rd) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    assign ReadData  = r_rdata;
    assign ReadValid = r_rvalid;
    assign AddrError = r_aerr;
    assign Busy      = ~w_ready;

endmodule
